rv_output_slice: RTL and testbench
==================================

// Module: rv_output_slice
// PURPOSE
//  Forward-registered ready/valid pipeline slice: two-entry elastic stage with registered
//  valid_out/data_out and registered ready_in. Sits on the consumer-facing end of a
//  channel, breaking both the forward timing path (valid/data) and the backward path (ready).
//  Sustains 1 transfer/cycle; 1-cycle latency.
// PARAMETERS
//  T      logic  payload type (packed struct or vector)
//  CNT_W  16     width of stall counter (STALL_CNT_EN only)
// PORTS
//  clk           in   1       clock; all state updates on posedge
//  reset_n       in   1       asynchronous, active-low reset
//  valid_in      in   1       upstream item valid
//  ready_in      out  1       slice can accept (registered)
//  data_in       in   $bits(T) upstream payload
//  valid_out     out  1       downstream item valid (registered)
//  ready_out     in   1       downstream accepts
//  data_out      out  $bits(T) downstream payload (registered)
//  occupancy     out  2       items held: 0, 1 or 2
//  stall_cycles  out  CNT_W   stall count (present only with STALL_CNT_EN)
// BEHAVIOUR
//  - Slots: main (drives valid_out/data_out) and skid. push = valid_in&&ready_in;
//    pop = valid_out&&ready_out. No combinational path from any input to any output.
//  - Reset (reset_n low, async): state EMPTY, valid_out=0, ready_in=1, data_out='0,
//    skid data='0, occupancy=0, stall_cycles=0. Reset mid-transfer drops both slots.
//  - States (rv_pkg::occ_e): EMPTY, ONE (main valid), FULL (main+skid valid).
//    EMPTY: push -> main<=data_in, ONE.
//    ONE:   push&&!pop -> skid<=data_in, FULL; push&&pop -> main<=data_in, ONE;
//           !push&&pop -> EMPTY; else hold.
//    FULL:  ready_in=0, so no push; pop -> main<=skid, ONE; else hold.
//  - ready_in = (state!=FULL); valid_out = (state!=EMPTY); both pure flop outputs.
//  - Order preserved; no item dropped or duplicated; data_out stable while valid_out&&!ready_out.
//  - Latency: item pushed in cycle N visible on data_out in N+1 (EMPTY/ONE-with-pop);
//    behind an older item otherwise.
//  - valid_in ignored when ready_in=0; upstream must hold data (standard rule).
//  - occupancy encodes state: EMPTY=0, ONE=1, FULL=2.
// CONFIGURATION
//  `define RV_OUTPUT_SLICE_STALL_CNT_EN:
//   with it: port stall_cycles exists; increments every cycle with valid_out&&!ready_out,
//   saturates at 2**CNT_W-1, cleared only by reset.
//   without it: port and counter are absent; behaviour otherwise identical.
// STRUCTURE
//  - rv_pkg: typedef enum logic [1:0] occ_e {EMPTY=0, ONE=1, FULL=2}; localparam OCC_W=2.
//  - No sub-module: one always_ff (async reset) for state/slots/counter, one always_comb
//    for next state. Shares T convention with the other ready/valid stages.
// TESTING
//  1 Reset: reset_n=0 mid-stream with FULL -> next cycle valid_out=0, ready_in=1, occ=0.
//  2 Streaming: ready_out=1, push 0x01..0x10 back-to-back -> data_out 0x01..0x10 one per
//    cycle, 1-cycle lag, occ stays 1, ready_in never drops.
//  3 Stall fill: push 0xA1,0xA2 with ready_out=0 -> occ=2, ready_in=0, data_out=0xA1
//    held; valid_in=1/0xA3 ignored while ready_in=0.
//  4 Drain: from test 3 raise ready_out -> 0xA1 then 0xA2, occ 2->1->0, ready_in=1
//    one cycle after first pop.
//  5 Random valid_in/ready_out (10k cycles) vs scoreboard -> in-order, no loss/dup,
//    data_out stable during stall.
//  6 STALL_CNT_EN, CNT_W=4: hold valid_out=1, ready_out=0 for 20 cycles -> stall_cycles=15.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared types for the ready/valid pipeline stages.
// Occupancy encoding used by the elastic slices.
package rv_pkg;

  localparam int OCC_W = 2;

  typedef enum logic [OCC_W-1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/rv_output_slice.sv
// Two-entry forward-registered ready/valid slice (main + skid slot).
// Optional stall counter: define RV_OUTPUT_SLICE_STALL_CNT_EN.
module rv_output_slice
  import rv_pkg::*;
#(
  parameter type T     = logic,
  parameter int  CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid_in,
  output logic             ready_in,
  input  T                 data_in,
  output logic             valid_out,
  input  logic             ready_out,
  output T                 data_out,
  output logic [OCC_W-1:0] occupancy
`ifdef RV_OUTPUT_SLICE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles
`endif
);

  occ_e state, state_nxt;
  T     main_q, main_nxt;
  T     skid_q, skid_nxt;
  logic push, pop;

  assign push      = valid_in && ready_in;
  assign pop       = valid_out && ready_out;
  assign data_out  = main_q;
  assign occupancy = OCC_W'(state);

  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    unique case (state)
      EMPTY: begin
        if (push) begin
          main_nxt  = data_in;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (push && !pop) begin
          skid_nxt  = data_in;
          state_nxt = FULL;
        end else if (push && pop) begin
          main_nxt  = data_in;
        end else if (pop) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          main_nxt  = skid_q;
          state_nxt = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Handshake outputs are flopped from the next state, not decoded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      valid_out <= 1'b0;
      ready_in  <= 1'b1;
    end else begin
      state     <= state_nxt;
      main_q    <= main_nxt;
      skid_q    <= skid_nxt;
      valid_out <= (state_nxt != EMPTY);
      ready_in  <= (state_nxt != FULL);
    end
  end

`ifdef RV_OUTPUT_SLICE_STALL_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
    end else if (valid_out && !ready_out
                 && stall_cycles != '1) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rv_output_slice.sv
// Bench for rv_output_slice: queue model plus directed literal checks.
// Stall counter checks compile in with RV_OUTPUT_SLICE_STALL_CNT_EN.
module tb_rv_output_slice;

  typedef logic [7:0] T;
  localparam int CNT_W = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       valid_in;
  logic       ready_in;
  T           data_in;
  logic       valid_out;
  logic       ready_out;
  T           data_out;
  logic [1:0] occupancy;
`ifdef RV_OUTPUT_SLICE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cycles;
`endif

  rv_output_slice #(.T(T), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .valid_in     (valid_in),
    .ready_in     (ready_in),
    .data_in      (data_in),
    .valid_out    (valid_out),
    .ready_out    (ready_out),
    .data_out     (data_out),
    .occupancy    (occupancy)
`ifdef RV_OUTPUT_SLICE_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  T   mq[$];
  int m_stall = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_stall = 0;
  endtask

  task automatic compare_model();
    chk("m_valid", 32'(valid_out), 32'(mq.size() > 0));
    chk("m_ready", 32'(ready_in), 32'(mq.size() < 2));
    chk("m_occ", 32'(occupancy), 32'(mq.size()));
    if (mq.size() > 0)
      chk("m_data", 32'(data_out), 32'(mq[0]));
`ifdef RV_OUTPUT_SLICE_STALL_CNT_EN
    chk("m_stall", 32'(stall_cycles), 32'(m_stall));
`endif
  endtask

  // One clock: drive, let the edge happen, advance model, compare.
  task automatic step(input logic vin, input T din,
                      input logic rout);
    bit do_push, do_pop;
    valid_in  = vin;
    data_in   = din;
    ready_out = rout;
    @(posedge clk);
    do_pop  = (mq.size() > 0) && rout;
    do_push = vin && (mq.size() < 2);
    if (mq.size() > 0 && !rout && m_stall < 2**CNT_W - 1)
      m_stall++;
    if (do_pop) void'(mq.pop_front());
    if (do_push) mq.push_back(din);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_ready", 32'(ready_in), 32'd1);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
`ifdef RV_OUTPUT_SLICE_STALL_CNT_EN
    chk("rst_stall", 32'(stall_cycles), 32'd0);
`endif
    reset_n = 1'b1;
  endtask

  initial begin
    bit hold;
    T   hdat;
    valid_in  = 1'b0;
    data_in   = '0;
    ready_out = 1'b0;
    do_reset();

    for (int i = 1; i <= 16; i++) begin
      step(1'b1, T'(i), 1'b1);
      chk("strm_data", 32'(data_out), 32'(i));
      chk("strm_occ", 32'(occupancy), 32'd1);
      chk("strm_ready", 32'(ready_in), 32'd1);
    end
    step(1'b0, '0, 1'b1);
    chk("strm_end_occ", 32'(occupancy), 32'd0);

    step(1'b1, 8'hA1, 1'b0);
    chk("fill1_data", 32'(data_out), 32'hA1);
    step(1'b1, 8'hA2, 1'b0);
    chk("fill2_occ", 32'(occupancy), 32'd2);
    chk("fill2_ready", 32'(ready_in), 32'd0);
    chk("fill2_data", 32'(data_out), 32'hA1);
    step(1'b1, 8'hA3, 1'b0);
    chk("ign_occ", 32'(occupancy), 32'd2);
    chk("ign_data", 32'(data_out), 32'hA1);

    step(1'b0, '0, 1'b1);
    chk("drn1_data", 32'(data_out), 32'hA2);
    chk("drn1_occ", 32'(occupancy), 32'd1);
    chk("drn1_ready", 32'(ready_in), 32'd1);
    step(1'b0, '0, 1'b1);
    chk("drn2_occ", 32'(occupancy), 32'd0);
    chk("drn2_valid", 32'(valid_out), 32'd0);

`ifdef RV_OUTPUT_SLICE_STALL_CNT_EN
    do_reset();
    step(1'b1, 8'h55, 1'b0);
    repeat (20) step(1'b0, '0, 1'b0);
    chk("stall_sat", 32'(stall_cycles), 32'd15);
    step(1'b0, '0, 1'b1);
`endif

    step(1'b1, 8'hB1, 1'b0);
    step(1'b1, 8'hB2, 1'b0);
    chk("pre_rst_occ", 32'(occupancy), 32'd2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_valid", 32'(valid_out), 32'd0);
    chk("async_ready", 32'(ready_in), 32'd1);
    chk("async_occ", 32'(occupancy), 32'd0);
    model_clear();
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, '0, 1'b0);

    hold = 1'b0;
    hdat = '0;
    for (int c = 0; c < 10000; c++) begin
      logic v, r;
      T d;
      v = hold ? 1'b1 : 1'($urandom_range(0, 1));
      d = hold ? hdat : T'($urandom);
      r = ($urandom_range(0, 3) != 0);
      hold = v && (mq.size() >= 2);
      hdat = d;
      step(v, d, r);
    end
    repeat (3) step(1'b0, '0, 1'b1);
    chk("final_occ", 32'(occupancy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
